// File: rtl/pipelined_wallace_tree.sv
// Three-stage 4:2 Wallace-tree reducer with optional low-column truncation; latency 3 cycles.
// Backpressure: every stage freezes while the output register holds an unaccepted result.
module pipelined_wallace_tree #(
  parameter int N_PP    = 8,
  parameter int PP_W    = 20,
  parameter int OUT_W   = 32,
  parameter int TRUNC_K = 4,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_PP*PP_W-1:0] pp,
  input  logic                 approx_en,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_approx
);

  localparam int HALF = N_PP / 2;
  typedef logic [OUT_W-1:0] word_t;

  logic              adv;
  word_t             mask;
  word_t             aligned [N_PP];
  word_t             s1_nxt [HALF];
  word_t             s2_nxt_a, s2_nxt_b;

  logic              s1_vld;
  word_t             s1_rows [HALF];
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_apx;

  logic              s2_vld;
  word_t             s2_a, s2_b;
  logic [TAG_W-1:0]  s2_tag;
  logic              s2_apx;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Truncation is applied per aligned row, so it follows the beat's own flag.
  assign mask = approx_en ? ~((word_t'(1) << TRUNC_K) - word_t'(1)) : '1;

  for (genvar i = 0; i < N_PP; i++) begin : g_align
    localparam int SH = (i < 2) ? 0 : 2 * (i - 1);
    assign aligned[i] = (word_t'(pp[i*PP_W +: PP_W]) << SH) & mask;
  end

  // First level: one 4:2 compressor (two chained 3:2 stages) per group of four rows.
  for (genvar g = 0; g < HALF / 2; g++) begin : g_c42
    word_t a, b, c, d, s0, c0;
    assign a  = aligned[4*g];
    assign b  = aligned[4*g+1];
    assign c  = aligned[4*g+2];
    assign d  = aligned[4*g+3];
    assign s0 = a ^ b ^ c;
    assign c0 = ((a & b) | (a & c) | (b & c)) << 1;
    assign s1_nxt[2*g]   = s0 ^ c0 ^ d;
    assign s1_nxt[2*g+1] = ((s0 & c0) | (s0 & d) | (c0 & d)) << 1;
  end

  // Remaining reduction down to a sum/carry pair; carries past the MSB drop out.
  always_comb begin
    word_t acc_s, acc_c, nxt_s;
    acc_s = s1_rows[0];
    acc_c = s1_rows[1];
    nxt_s = '0;
    for (int k = 2; k < HALF; k++) begin
      nxt_s = acc_s ^ acc_c ^ s1_rows[k];
      acc_c = ((acc_s & acc_c) | (acc_s & s1_rows[k]) | (acc_c & s1_rows[k])) << 1;
      acc_s = nxt_s;
    end
    s2_nxt_a = acc_s;
    s2_nxt_b = acc_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      out_tag    <= '0;
      out_approx <= 1'b0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (s2_vld) begin
        result     <= s2_a + s2_b;
        out_tag    <= s2_tag;
        out_approx <= s2_apx;
      end
    end
  end

  // Payload registers only move with a valid beat, so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (!rst && adv) begin
      if (in_valid) begin
        s1_rows <= s1_nxt;
        s1_tag  <= in_tag;
        s1_apx  <= approx_en;
      end
      if (s1_vld) begin
        s2_a   <= s2_nxt_a;
        s2_b   <= s2_nxt_b;
        s2_tag <= s1_tag;
        s2_apx <= s1_apx;
      end
    end
  end

endmodule

// File: doc/pipelined_wallace_tree.md
PIPELINED_WALLACE_TREE -- requirements
Module: pipelined_wallace_tree

Interface
REQ-001 The module SHALL have parameter N_PP, default 8, meaning the number of partial-product rows; legal values are multiples of 4 that are at least 4.
REQ-002 The module SHALL have parameter PP_W, default 20, meaning the width of each partial-product row.
REQ-003 The module SHALL have parameter OUT_W, default 32, meaning the result width; OUT_W >= PP_W + 2*(N_PP-2) is required.
REQ-004 The module SHALL have parameter TRUNC_K, default 4, meaning the number of low result columns dropped in approximate mode; legal range is 0..OUT_W-1.
REQ-005 The module SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag.
REQ-006 The module SHALL have ports clk, input, 1 bit: the single clock, rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The module SHALL have port pp, input, N_PP*PP_W bits: row i occupies bits [i*PP_W +: PP_W].
REQ-011 The module SHALL have port approx_en, input, 1 bit: selects approximate mode for this beat.
REQ-012 The module SHALL have port in_tag, input, TAG_W bits: user tag that travels with the beat.
REQ-013 The module SHALL have port out_valid, output, 1 bit: a result is present.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-015 The module SHALL have port result, output, OUT_W bits: the reduced sum.
REQ-016 The module SHALL have port out_tag, output, TAG_W bits: the tag of the result beat.
REQ-017 The module SHALL have port out_approx, output, 1 bit: the approx_en value of the result beat.

Function
REQ-018 Row alignment SHALL be: rows 0 and 1 unshifted; row i (i>=2) left-shifted by 2*(i-1); all rows zero-extended to OUT_W.
REQ-019 Exact mode (approx_en=0) SHALL give result = sum of all aligned rows mod 2^OUT_W.
REQ-020 Approximate mode (approx_en=1) SHALL zero bits [TRUNC_K-1:0] of every aligned row before summation, result = sum of masked rows mod 2^OUT_W; TRUNC_K=0 makes it identical to exact mode.
REQ-021 The pipeline SHALL have three registered stages: S1 = first 4:2 compressor level (N_PP rows to N_PP/2 rows), S2 = remaining compressor levels down to 2 rows, S3 = final carry-propagate add into the result register.
REQ-022 Every stage SHALL carry a valid bit, the tag and the approx flag alongside its data.
REQ-023 The advance signal SHALL be adv = ~out_valid | out_ready; all stage registers load only when adv=1; in_ready = adv.
REQ-024 A beat SHALL be accepted when in_valid & in_ready; S1 valid loads in_valid & adv.
REQ-025 Latency SHALL be exactly 3 cycles from acceptance to out_valid when out_ready stays 1.
REQ-026 Throughput SHALL be 1 beat per cycle.
REQ-027 Bubbles SHALL propagate rather than collapse.
REQ-028 While out_valid=1 and out_ready=0, result, out_tag, out_approx and all stage contents SHALL hold unchanged, and in_ready SHALL be 0.
REQ-029 A simultaneous output handshake and input acceptance in the same cycle SHALL shift the pipeline once, with no loss or duplication.
REQ-030 approx_en SHALL be sampled per beat; mixing modes on consecutive beats SHALL be legal, and each beat's result reflects its own flag.
REQ-031 Carries beyond bit OUT_W-1 SHALL be discarded; there is no overflow flag.

Reset
REQ-032 While rst=1 at a clock edge, all stage valid bits, out_valid, result, out_tag and out_approx SHALL become 0.
REQ-033 in_ready SHALL be 1 in the cycle after reset because out_valid=0.
REQ-034 Assertion of rst mid-operation SHALL discard all in-flight beats; none are ever emitted.
REQ-035 A beat presented during a reset cycle SHALL NOT be accepted.

Verification (defaults N_PP=8, PP_W=20, OUT_W=32, TRUNC_K=4)
REQ-036 Directed test: pp0=1, pp7=1, others 0, approx_en=0 -> result 0x00001001, exactly 3 cycles after acceptance.
REQ-037 Directed test: all rows 20'hFFFFF, approx_en=0 -> result 0x555FEAAA; same beat with approx_en=1 -> result 0x555FEA80, out_approx=1.
REQ-038 Directed test: four back-to-back beats with out_ready=1 -> four consecutive out_valid cycles with tags in order 0,1,2,3.
REQ-039 Directed test: hold out_ready=0 for 5 cycles with 3 beats in flight -> result and out_tag stable, in_ready=0; on release, the 3 beats emerge in order, none lost or duplicated.
REQ-040 Directed test: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and result=0 from the next cycle, and neither beat ever appears.
